adc0809_responder: RTL

ADC0809_RESPONDER -- requirements
Module: adc0809_responder

---
 rtl/adc0809_if.sv | 33 +++
 rtl/adc0809_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adc0809_if.sv
// Bus bundle between an ADC0809-style host and the responder.
// The optional ovr flag exists only when ADC_RESPONDER_OVR_EN is defined.
interface adc0809_if;
  logic        a;
  logic        b;
  logic        c;
  logic        ale;
  logic        start;
  logic        oe;
  logic [63:0] ch_data;
  logic        eoc;
  logic [7:0]  data_out;
  logic        busy;
`ifdef ADC_RESPONDER_OVR_EN
  logic        ovr;
`endif

  modport master (
    output a, b, c, ale, start, oe, ch_data,
`ifdef ADC_RESPONDER_OVR_EN
    input  ovr,
`endif
    input  eoc, data_out, busy
  );

  modport slave (
    input  a, b, c, ale, start, oe, ch_data,
`ifdef ADC_RESPONDER_OVR_EN
    output ovr,
`endif
    output eoc, data_out, busy
  );
endinterface

// File: rtl/adc0809_responder.sv
// Cycle-level emulation of an ADC0809 successive-approximation converter.
// Define ADC_RESPONDER_OVR_EN to add the unread-result overrun flag (ovr).
module adc0809_responder #(
  parameter int unsigned STEP_CYCLES = 8,
  parameter int unsigned EOC_DLY     = 2
) (
  input  logic     clk_in,
  input  logic     rst,
  adc0809_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_EOC_WAIT,
    S_CONVERT,
    S_DONE
  } state_e;

  localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);
  localparam logic [3:0] DLY_LAST  = 4'(EOC_DLY - 1);

  state_e     state_q, state_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] sar_q, sar_d;
  logic [7:0] sample_q, sample_d;
  logic [7:0] result_q, result_d;
  logic [3:0] dly_cnt_q, dly_cnt_d;
  logic [7:0] step_cnt_q, step_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       eoc_q, eoc_d;
  logic       busy_q, busy_d;
  logic       ale_q, start_q;

  logic       ale_rise, start_rise, start_fall;
  logic       enter_convert, abort, complete;
  logic [7:0] decided, next_trial;

  assign ale_rise   = bus.ale & ~ale_q;
  assign start_rise = bus.start & ~start_q;
  assign start_fall = ~bus.start & start_q;

  // The trial bit survives only if the trial value does not exceed the held sample.
  assign decided    = (sar_q <= sample_q) ? sar_q : (sar_q & ~(8'h01 << bit_idx_q));
  assign next_trial = decided | (8'h01 << (bit_idx_q - 3'd1));

  // NOTE: every _d gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    sar_d         = sar_q;
    sample_d      = sample_q;
    result_d      = result_q;
    dly_cnt_d     = dly_cnt_q;
    step_cnt_d    = step_cnt_q;
    bit_idx_d     = bit_idx_q;
    eoc_d         = eoc_q;
    busy_d        = busy_q;
    enter_convert = 1'b0;
    abort         = 1'b0;
    complete      = 1'b0;

    if (ale_rise && state_q != S_CONVERT && state_q != S_EOC_WAIT) begin
      addr_d = {bus.c, bus.b, bus.a};
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          state_d = S_ARMED;
          sar_d   = 8'h00;
          busy_d  = 1'b1;
        end
      end
      S_ARMED: begin
        if (start_fall) begin
          sample_d = bus.ch_data[{addr_q, 3'b000} +: 8];
          if (EOC_DLY == 1) begin
            enter_convert = 1'b1;
          end else begin
            state_d   = S_EOC_WAIT;
            dly_cnt_d = 4'd1;
          end
        end
      end
      S_EOC_WAIT: begin
        if (start_rise) begin
          abort = 1'b1;
        end else if (dly_cnt_q == DLY_LAST) begin
          enter_convert = 1'b1;
        end else begin
          dly_cnt_d = dly_cnt_q + 4'd1;
        end
      end
      S_CONVERT: begin
        if (start_rise) begin
          abort = 1'b1;
        end else if (step_cnt_q == STEP_LAST) begin
          if (bit_idx_q == 3'd0) begin
            sar_d    = decided;
            result_d = decided;
            eoc_d    = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_DONE;
            complete = 1'b1;
          end else begin
            sar_d      = next_trial;
            bit_idx_d  = bit_idx_q - 3'd1;
            step_cnt_d = 8'd0;
          end
        end else begin
          step_cnt_d = step_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_convert) begin
      state_d    = S_CONVERT;
      eoc_d      = 1'b0;
      sar_d      = 8'h80;
      step_cnt_d = 8'd0;
      bit_idx_d  = 3'd7;
    end

    // Abort restarts from ARMED; the last completed result stays readable.
    if (abort) begin
      state_d    = S_ARMED;
      sar_d      = 8'h00;
      eoc_d      = 1'b1;
      busy_d     = 1'b1;
      dly_cnt_d  = 4'd0;
      step_cnt_d = 8'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 3'd0;
      sar_q      <= 8'h00;
      sample_q   <= 8'h00;
      result_q   <= 8'h00;
      dly_cnt_q  <= 4'd0;
      step_cnt_q <= 8'd0;
      bit_idx_q  <= 3'd0;
      eoc_q      <= 1'b1;
      busy_q     <= 1'b0;
      ale_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sar_q      <= sar_d;
      sample_q   <= sample_d;
      result_q   <= result_d;
      dly_cnt_q  <= dly_cnt_d;
      step_cnt_q <= step_cnt_d;
      bit_idx_q  <= bit_idx_d;
      eoc_q      <= eoc_d;
      busy_q     <= busy_d;
      ale_q      <= bus.ale;
      start_q    <= bus.start;
    end
  end

  assign bus.eoc      = eoc_q;
  assign bus.busy     = busy_q;
  assign bus.data_out = bus.oe ? result_q : 8'h00;

`ifdef ADC_RESPONDER_OVR_EN
  logic unread_q, unread_d;
  logic ovr_q, ovr_d;

  // A completion over an unread result raises ovr even if oe clears it that cycle.
  always_comb begin
    unread_d = unread_q;
    ovr_d    = ovr_q;
    if (bus.oe) begin
      unread_d = 1'b0;
      ovr_d    = 1'b0;
    end
    if (complete) begin
      unread_d = 1'b1;
      if (unread_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      unread_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      unread_q <= unread_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.ovr = ovr_q;
`endif

endmodule
